// File: rtl/vreg_if.sv
// vreg_if: write-stream and dual read-stream bundle between vreg_file and its clients.
interface vreg_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          wr_start;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic [DW-1:0] data_in;
    logic          wr_busy;
    logic          wr_done;
    logic          rd_start;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr2;
    logic          rd_stall;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_out2;
    logic          rd_valid;
    logic          rd_done;
    logic          err;

    modport master (
        output wr_start, wr_addr, wr_valid, data_in, rd_start, rd_addr, rd_addr2, rd_stall,
        input  wr_busy, wr_done, data_out, data_out2, rd_valid, rd_done, err
    );

    modport slave (
        input  wr_start, wr_addr, wr_valid, data_in, rd_start, rd_addr, rd_addr2, rd_stall,
        output wr_busy, wr_done, data_out, data_out2, rd_valid, rd_done, err
    );
endinterface

// File: rtl/vreg_file.sv
// vreg_file: NREG x VLEN x DW vector register file, one serial write stream, two lock-stepped read streams.
// Define VREG_BYPASS_EN to forward same-cycle write data to colliding read issues.
module vreg_file #(
    parameter  int DW   = 16,
    parameter  int VLEN = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG),
    localparam int EW   = $clog2(VLEN)
) (
    input logic   i_clk,
    input logic   i_rst_n,
    vreg_if.slave io_bus
);
    typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
    typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

    logic [DW-1:0] r_mem [NREG][VLEN];
    w_state_t      r_wstate, w_wstate_nx;
    r_state_t      r_rstate, w_rstate_nx;
    logic [EW-1:0] r_widx, w_widx_nx, r_ridx, w_ridx_nx, w_wi, w_ri;
    logic [AW-1:0] r_waddr, r_raddr, r_raddr2, w_wa, w_ra, w_ra2;
    logic [DW-1:0] r_dout, r_dout2, w_rd, w_rd2;
    logic          r_rd_valid, r_rd_done, r_wr_done, r_err;
    logic          w_wact, w_wlast, w_wacc, w_we;
    logic          w_ract, w_rlast, w_racc, w_iss;

    // Idle-state accepts take address/index straight from the ports so the accept cycle can move data.
    always_comb begin
        w_wact      = r_wstate == W_ACTIVE;
        w_wlast     = w_wact && io_bus.wr_valid && r_widx == EW'(VLEN - 1);
        w_wacc      = io_bus.wr_start && (!w_wact || w_wlast);
        w_wa        = w_wact ? r_waddr : io_bus.wr_addr;
        w_wi        = w_wact ? r_widx : '0;
        w_we        = i_rst_n && io_bus.wr_valid && (w_wact || w_wacc);
        w_widx_nx   = w_wi + EW'(w_we);
        w_wstate_nx = w_wacc ? W_ACTIVE : w_wlast ? W_IDLE : r_wstate;
        w_ract      = r_rstate == R_ACTIVE;
        w_rlast     = w_ract && !io_bus.rd_stall && r_ridx == EW'(VLEN - 1);
        w_racc      = io_bus.rd_start && (!w_ract || w_rlast);
        w_ra        = w_ract ? r_raddr : io_bus.rd_addr;
        w_ra2       = w_ract ? r_raddr2 : io_bus.rd_addr2;
        w_ri        = w_ract ? r_ridx : '0;
        w_iss       = !io_bus.rd_stall && (w_ract || w_racc);
        w_ridx_nx   = w_ri + EW'(w_iss);
        w_rstate_nx = w_racc ? R_ACTIVE : w_rlast ? R_IDLE : r_rstate;
`ifdef VREG_BYPASS_EN
        w_rd        = (w_we && w_wa == w_ra && w_wi == w_ri) ? io_bus.data_in : r_mem[w_ra][w_ri];
        w_rd2       = (w_we && w_wa == w_ra2 && w_wi == w_ri) ? io_bus.data_in : r_mem[w_ra2][w_ri];
`else
        w_rd        = r_mem[w_ra][w_ri];
        w_rd2       = r_mem[w_ra2][w_ri];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_wa][w_wi] <= io_bus.data_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wstate   <= W_IDLE;
            r_rstate   <= R_IDLE;
            r_widx     <= '0;
            r_ridx     <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_raddr2   <= '0;
            r_dout     <= '0;
            r_dout2    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wstate   <= w_wstate_nx;
            r_rstate   <= w_rstate_nx;
            r_widx     <= w_widx_nx;
            r_ridx     <= w_ridx_nx;
            if (w_wacc) r_waddr <= io_bus.wr_addr;
            if (w_racc) begin
                r_raddr  <= io_bus.rd_addr;
                r_raddr2 <= io_bus.rd_addr2;
            end
            if (w_iss) begin
                r_dout  <= w_rd;
                r_dout2 <= w_rd2;
            end
            r_rd_valid <= w_iss;
            r_rd_done  <= w_iss && w_ri == EW'(VLEN - 1);
            r_wr_done  <= w_wlast;
            r_err      <= (io_bus.wr_start && !w_wacc) || (io_bus.rd_start && !w_racc);
        end
    end

    assign io_bus.wr_busy   = r_wstate == W_ACTIVE;
    assign io_bus.wr_done   = r_wr_done;
    assign io_bus.data_out  = r_dout;
    assign io_bus.data_out2 = r_dout2;
    assign io_bus.rd_valid  = r_rd_valid;
    assign io_bus.rd_done   = r_rd_done;
    assign io_bus.err       = r_err;
endmodule

// File: doc/vreg_file.md
# vreg_file

Parametrised vector register file: NREG vectors of VLEN elements, DW bits each, streamed one element per clock. One serial write port and two lock-stepped serial read ports with start/valid/done handshakes, explicit stall and collision detection. Sits between the vector load/store unit (write side) and the vector ALU operand fetch (two read streams). Successor to the fixed 8x16x16 dual-clock register bank; this block uses a single clock.

## Interface
- DW, 16, element width in bits
- VLEN, 16, elements per vector (power of 2, >= 2)
- NREG, 8, number of vector registers (power of 2, >= 2)
- AW, $clog2(NREG), register address width (derived)
- EW, $clog2(VLEN), element index width (derived)

- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- WrStart  in  1  begin write burst to register WrAddr
- WrAddr  in  AW  destination register, sampled on accepted WrStart
- WrValid  in  1  DataIn holds a valid element this cycle
- DataIn  in  DW  write element
- WrBusy  out  1  write burst in progress
- WrDone  out  1  one-cycle pulse after final element is written
- RdStart  in  1  begin read burst
- RdAddr  in  AW  source register, port 1, sampled on accepted RdStart
- RdAddr2  in  AW  source register, port 2, sampled on accepted RdStart
- RdStall  in  1  hold read stream this cycle
- DataOut  out  DW  port 1 element
- DataOut2  out  DW  port 2 element, same index as DataOut
- RdValid  out  1  DataOut/DataOut2 valid this cycle
- RdDone  out  1  high with the last RdValid of a burst
- Err  out  1  one-cycle pulse: start request rejected

## Operation
- Storage: NREG x VLEN x DW array, not reset (contents undefined after reset).
- Write FSM, states W_IDLE, W_ACTIVE. Counter wIdx (EW bits), latched wAddr.
  - WrStart accepted in W_IDLE, or in W_ACTIVE on the cycle its final element is written. On acceptance: wAddr <= WrAddr, wIdx <= 0, go to W_ACTIVE.
  - The accept cycle also writes element 0 when WrValid=1 (address taken directly from WrAddr).
  - Each cycle with WrValid=1 and a burst active: mem[wAddr][wIdx] <= DataIn, wIdx++. WrValid=0 inserts a gap and writes nothing.
  - When element VLEN-1 is written, wIdx wraps to 0. Next cycle WrDone=1, and W_IDLE unless a new burst was accepted. WrBusy=1 in W_ACTIVE.
- Read FSM, states R_IDLE, R_ACTIVE. Counter rIdx, latched rAddr/rAddr2.
  - Acceptance rule is the same as for write, but applies to the final issue.
  - Each active cycle with RdStall=0 (including the accept cycle) issues mem[rAddr][rIdx] and mem[rAddr2][rIdx], then rIdx++. RdStall=1 issues nothing.
  - After issue VLEN-1 goes out, return to R_IDLE unless restarted.
- Err pulses for one cycle when a start arrives while that FSM is active and not on its final cycle. The start is ignored. Write and read errors are ORed.
- Rd and Wr bursts are fully independent and may overlap on the same register.
- Collision: an issue of element (a,k) in the same cycle as a write of (a,k) returns old data, unless VREG_BYPASS_EN is defined.
- Reset mid-burst aborts both bursts. Partially written data stays in the array.

## Timing
- Reset values: DataOut=0, DataOut2=0, RdValid=0, RdDone=0, WrBusy=0, WrDone=0, Err=0. Both FSMs go to IDLE and all counters to 0.
- Write latency: an element written at edge T is readable by an issue at T+1.
- Read latency: 1 cycle. An issue in cycle T gives RdValid=1 with data in T+1. A non-issue cycle gives RdValid=0, and DataOut/DataOut2 hold their last value.
- An unstalled burst takes VLEN+1 cycles from RdStart to the last RdValid.
- Back-to-back bursts produce continuous RdValid with no bubble.
- Err, WrDone and RdDone are registered, appearing one cycle after the causing event (RdDone aligns with the data).

## Configuration
- VREG_BYPASS_EN defined: forward DataIn to the read outputs when an issued element matches the (register, index) being written that cycle. Each port is compared independently.
- VREG_BYPASS_EN undefined: on that collision the read returns the pre-write array value.

## Test plan
- Write reg 2 with elements 16'hA000..A00F (WrValid steady), then read RdAddr=2, RdAddr2=2 -> WrDone one cycle after the 16th write. DataOut=DataOut2=A000..A00F on 16 consecutive RdValid cycles, RdDone with A00F.
- Read reg 2 on port 1 and reg 5 (preloaded 16'h5000+k) on port 2, with RdStall high on cycles 3 and 4 -> exactly 16 valid pairs (A00k, 500k), outputs held during stall bubbles.
- RdStart on the final issue cycle of a burst (new addr 5) -> 32 contiguous RdValid cycles with no gap. RdStart mid-burst -> Err pulse, stream unaffected.
- Write reg 3 with 16'h3000+k while reading reg 3 started the same cycle -> with VREG_BYPASS_EN every element reads 16'h300k; without it, old contents.
- Drop Rst_n during a write at element 7 -> all outputs 0 immediately, WrBusy=0. Elements 0..6 are retained and readable; a new WrStart is accepted normally.
- WrValid gaps of 2 cycles every 4 elements -> 16 elements written in order, WrDone exactly once.
